divider_arbiter: RTL

- Shares one sequential restoring divider (start/ready handshake, WIDTH-bit A/B in, Q/R out) between two requesters.
- Round-robin arbitration; latches the winner's operands and drives the divider start pulse.
- Tracks the divider's busy/ready cycle and routes the registered quotient/remainder back to the owning requester with a one-cycle done pulse.
- Sits between two client FSMs and the divider top level.

---
 rtl/divider_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one start/ready sequential divider between two requesters.
// Optional macro DIV_ZERO_BYPASS_EN answers b==0 locally instead of starting the divider.
module divider_arbiter #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             ack0,
    output logic             done0,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] r0,
    output logic             err0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack1,
    output logic             done1,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] r1,
    output logic             err1,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic             last_q;
    logic             owner_q;
    logic             ack0_q, ack1_q, done0_q, done1_q, err0_q, err1_q;
    logic [WIDTH-1:0] q0_q, r0_q, q1_q, r1_q;
    logic             div_start_q, busy_q;
    logic [WIDTH-1:0] div_a_q, div_b_q;
`ifdef DIV_ZERO_BYPASS_EN
    logic             bypass_q;
`endif

    logic             grant_any_d;
    logic             grant_sel_d;
    logic [WIDTH-1:0] grant_a_d;
    logic [WIDTH-1:0] grant_b_d;

    // Round-robin winner selection: on a tie the requester that was not served last wins.
    always_comb begin
        grant_any_d = req0 | req1;
        if (req0 && req1) begin
            grant_sel_d = ~last_q;
        end else if (req1) begin
            grant_sel_d = 1'b1;
        end else begin
            grant_sel_d = 1'b0;
        end
        if (grant_sel_d) begin
            grant_a_d = a1;
            grant_b_d = b1;
        end else begin
            grant_a_d = a0;
            grant_b_d = b0;
        end
    end

    // Arbitration FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            q0_q        <= '0;
            r0_q        <= '0;
            q1_q        <= '0;
            r1_q        <= '0;
            div_start_q <= 1'b0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            busy_q      <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
            bypass_q    <= 1'b0;
`endif
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            div_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any_d) begin
                        div_a_q <= grant_a_d;
                        div_b_q <= grant_b_d;
                        owner_q <= grant_sel_d;
                        last_q  <= grant_sel_d;
                        ack0_q  <= ~grant_sel_d;
                        ack1_q  <= grant_sel_d;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
`ifdef DIV_ZERO_BYPASS_EN
                        bypass_q    <= (grant_b_d == '0);
                        div_start_q <= (grant_b_d != '0);
`else
                        div_start_q <= 1'b1;
`endif
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
`ifdef DIV_ZERO_BYPASS_EN
                    // Divide by zero never reaches the divider: all-ones quotient, dividend as remainder.
                    if (bypass_q) begin
                        if (owner_q) begin
                            q1_q    <= '1;
                            r1_q    <= div_a_q;
                            err1_q  <= 1'b1;
                            done1_q <= 1'b1;
                        end else begin
                            q0_q    <= '1;
                            r0_q    <= div_a_q;
                            err0_q  <= 1'b1;
                            done0_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_BUSY;
                    end
`else
                    state_q <= WAIT_BUSY;
`endif
                end
                WAIT_BUSY: begin
                    if (!div_ready) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        state_q <= WAIT_BUSY;
                    end
                end
                WAIT_DONE: begin
                    if (div_ready) begin
                        if (owner_q) begin
                            q1_q    <= div_q;
                            r1_q    <= div_r;
                            err1_q  <= 1'b0;
                            done1_q <= 1'b1;
                        end else begin
                            q0_q    <= div_q;
                            r0_q    <= div_r;
                            err0_q  <= 1'b0;
                            done0_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign q0        = q0_q;
    assign r0        = r0_q;
    assign q1        = q1_q;
    assign r1        = r1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign div_start = div_start_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign busy      = busy_q;

endmodule
